// File: rtl/breakout_pkg.sv
// Shared breakout constants: FSM state encoding, brick grid geometry and playfield bounds.
package breakout_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        LOST_LIFE = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_t;

    localparam int GRID_ROWS  = 5;
    localparam int GRID_COLS  = 12;
    localparam int NUM_BRICKS = GRID_ROWS * GRID_COLS;

    // Playfield bounds in pixels, shared with the pixel/ball logic.
    localparam int FLOOR_Y      = 470;
    localparam int CEILING_Y    = 10;
    localparam int LEFT_WALL_X  = 10;
    localparam int RIGHT_WALL_X = 630;

    function automatic logic [5:0] brick_index(input int row, input int col);
        return 6'(row * GRID_COLS + col);
    endfunction

endpackage

// File: rtl/breakout_sequencer_frame_delay.sv
// Loadable down-counter of frame ticks; done pulses on the tick that exhausts the load value.
module frame_delay #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] cnt;
    logic [W-1:0] cur;

    // Loading in the same cycle lets a tick on that cycle count as the first one.
    assign cur  = load ? load_val : cnt;
    assign done = tick && (cur == W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick && cur != '0) begin
            cnt <= cur - W'(1);
        end else begin
            cnt <= cur;
        end
    end

endmodule

// File: rtl/breakout_sequencer.sv
// Breakout game controller: play FSM, brick bitmap, lives, score and ball speed level.
module breakout_sequencer
    import breakout_pkg::*;
#(
    parameter int NUM_BRICKS       = 60,
    parameter int LIVES_INIT       = 3,
    parameter int SERVE_FRAMES     = 60,
    parameter int HOLD_FRAMES      = 30,
    parameter int BRICKS_PER_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic                  brick_hit,
    input  logic [5:0]            brick_idx,
    input  logic                  ball_lost,
    output logic [2:0]            state,
    output logic                  ball_run,
    output logic                  ball_serve,
    output logic [NUM_BRICKS-1:0] bricks_alive,
    output logic [1:0]            lives,
    output logic [11:0]           score,
    output logic [1:0]            speed_level
);

    localparam int LW = $clog2(NUM_BRICKS + 1);
    localparam int FW = 16;

    state_t        st;
    logic          entry;
    logic [LW-1:0] bricks_left;
    logic [LW-1:0] left_n;
    logic          hit_ok;
    logic          fd_done;
    logic [11:0]   score_n;
    logic [1:0]    spd_n;
    int            cleared;
    int            lvl;

    assign state = st;

    always_comb begin
        hit_ok = 1'b0;
        if (brick_hit && int'(brick_idx) < NUM_BRICKS)
            hit_ok = bricks_alive[brick_idx];
        left_n  = bricks_left - LW'(hit_ok);
        cleared = NUM_BRICKS - int'(left_n);
        lvl     = cleared / BRICKS_PER_LEVEL;
        spd_n   = (lvl > 3) ? 2'd3 : 2'(lvl);
        score_n = (score == 12'hFFF) ? score : score + 12'd1;
    end

    // One counter serves both timed states; it reloads on the first cycle of each state.
    frame_delay #(.W(FW)) u_frame_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (entry),
        .load_val ((st == SERVE) ? FW'(SERVE_FRAMES) : FW'(HOLD_FRAMES)),
        .tick     (frame_tick),
        .done     (fd_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= IDLE;
            entry        <= 1'b0;
            ball_run     <= 1'b0;
            ball_serve   <= 1'b0;
            bricks_alive <= '1;
            lives        <= 2'(LIVES_INIT);
            score        <= '0;
            speed_level  <= '0;
            bricks_left  <= LW'(NUM_BRICKS);
        end else begin
            ball_serve <= 1'b0;
            entry      <= 1'b0;
            case (st)
                IDLE, GAME_OVER, WIN: begin
                    if (start) begin
                        bricks_alive <= '1;
                        lives        <= 2'(LIVES_INIT);
                        score        <= '0;
                        speed_level  <= '0;
                        bricks_left  <= LW'(NUM_BRICKS);
                        st           <= SERVE;
                        entry        <= 1'b1;
                        ball_serve   <= 1'b1;
                        ball_run     <= 1'b0;
                    end
                end
                SERVE: begin
                    if (fd_done) begin
                        st       <= PLAY;
                        entry    <= 1'b1;
                        ball_run <= 1'b1;
                    end
                end
                PLAY: begin
                    if (hit_ok) begin
                        bricks_alive[brick_idx] <= 1'b0;
                        score                   <= score_n;
                        bricks_left             <= left_n;
                        speed_level             <= spd_n;
                    end
                    // Clearing the last brick wins even if the ball drops in the same cycle.
                    if (hit_ok && left_n == '0) begin
                        st       <= WIN;
                        entry    <= 1'b1;
                        ball_run <= 1'b0;
                    end else if (ball_lost) begin
                        if (lives <= 2'd1) begin
                            lives <= 2'd0;
                            st    <= GAME_OVER;
                        end else begin
                            lives <= lives - 2'd1;
                            st    <= LOST_LIFE;
                        end
                        entry    <= 1'b1;
                        ball_run <= 1'b0;
                    end
                end
                LOST_LIFE: begin
                    if (fd_done) begin
                        st         <= SERVE;
                        entry      <= 1'b1;
                        ball_serve <= 1'b1;
                    end
                end
                default: begin
                    st       <= IDLE;
                    entry    <= 1'b1;
                    ball_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_breakout_sequencer.sv
// Scoreboard bench: stimulus pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_breakout_sequencer;
    import breakout_pkg::*;

    logic        clk = 1'b0;
    logic        rst, frame_tick, start, brick_hit, ball_lost;
    logic [5:0]  brick_idx;
    logic [2:0]  state;
    logic        ball_run, ball_serve;
    logic [59:0] bricks_alive;
    logic [1:0]  lives;
    logic [11:0] score;
    logic [1:0]  speed_level;

    always #5 clk = ~clk;

    breakout_sequencer #(
        .NUM_BRICKS(60), .LIVES_INIT(3), .SERVE_FRAMES(60),
        .HOLD_FRAMES(30), .BRICKS_PER_LEVEL(12)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .brick_hit(brick_hit), .brick_idx(brick_idx), .ball_lost(ball_lost),
        .state(state), .ball_run(ball_run), .ball_serve(ball_serve),
        .bricks_alive(bricks_alive), .lives(lives), .score(score),
        .speed_level(speed_level)
    );

    typedef struct {
        string       nm;
        int          cyc;
        logic [2:0]  st;
        logic        run;
        logic        serve;
        logic [1:0]  lives;
        logic [11:0] score;
        logic [1:0]  spd;
        logic [59:0] bricks;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  e_st;
    logic        e_run, e_serve;
    logic [1:0]  e_lives;
    logic [11:0] e_score;
    logic [1:0]  e_spd;
    logic [59:0] e_bricks;
    int          e_left;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (state !== e.st || ball_run !== e.run || ball_serve !== e.serve ||
                    lives !== e.lives || score !== e.score || speed_level !== e.spd ||
                    bricks_alive !== e.bricks) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got st=%0d run=%0d serve=%0d lives=%0d score=%0d spd=%0d bricks=%h exp st=%0d run=%0d serve=%0d lives=%0d score=%0d spd=%0d bricks=%h",
                             e.nm, e.cyc, state, ball_run, ball_serve, lives, score, speed_level,
                             bricks_alive, e.st, e.run, e.serve, e.lives, e.score, e.spd, e.bricks);
                end
            end
        end
    end

    task automatic set_reset_exp();
        e_st = IDLE; e_run = 1'b0; e_serve = 1'b0; e_lives = 2'd3;
        e_score = '0; e_spd = '0; e_bricks = '1; e_left = 60;
    endtask

    task automatic step(input string nm);
        exp_t e;
        e.nm = nm; e.cyc = cyc + 1; e.st = e_st; e.run = e_run; e.serve = e_serve;
        e.lives = e_lives; e.score = e_score; e.spd = e_spd; e.bricks = e_bricks;
        q.push_back(e);
        @(posedge clk); #1;
        start = 0; brick_hit = 0; ball_lost = 0; frame_tick = 0; brick_idx = '0;
        e_serve = 1'b0;
    endtask

    task automatic do_serve(input string nm);
        for (int i = 1; i <= 60; i++) begin
            frame_tick = 1;
            if (i == 60) begin e_st = PLAY; e_run = 1'b1; end
            step($sformatf("%s_tick%0d", nm, i));
            if (i < 60) step($sformatf("%s_gap%0d", nm, i));
        end
    endtask

    task automatic do_hold(input string nm);
        for (int i = 1; i <= 30; i++) begin
            frame_tick = 1;
            if (i == 30) begin e_st = SERVE; e_serve = 1'b1; end
            step($sformatf("%s_tick%0d", nm, i));
            if (i < 30) step($sformatf("%s_gap%0d", nm, i));
        end
    endtask

    // PLAY-state event with expected effect worked out from the game rules.
    task automatic ev(input bit h, input int idx, input bit lost, input string nm);
        int clr;
        brick_hit = h; brick_idx = 6'(idx); ball_lost = lost;
        if (h && idx < 60 && e_bricks[idx]) begin
            e_bricks[idx] = 1'b0;
            e_score = e_score + 12'd1;
            e_left--;
        end
        clr = 60 - e_left;
        e_spd = (clr >= 36) ? 2'd3 : (clr >= 24) ? 2'd2 : (clr >= 12) ? 2'd1 : 2'd0;
        if (e_left == 0) begin
            e_st = WIN; e_run = 1'b0;
        end else if (lost) begin
            if (e_lives == 2'd1) begin e_lives = 2'd0; e_st = GAME_OVER; end
            else begin e_lives = e_lives - 2'd1; e_st = LOST_LIFE; end
            e_run = 1'b0;
        end
        step(nm);
    endtask

    initial begin
        rst = 1; frame_tick = 0; start = 0; brick_hit = 0; ball_lost = 0; brick_idx = '0;
        set_reset_exp();
        step("reset0");
        step("reset1");
        rst = 0;
        brick_hit = 1; brick_idx = 6'd3; ball_lost = 1;
        step("idle_events_ignored");
        frame_tick = 1;
        step("idle_tick");
        start = 1; e_st = SERVE; e_serve = 1'b1;
        step("start");
        start = 1;
        step("serve_start_ignored");
        brick_hit = 1; ball_lost = 1;
        step("serve_events_ignored");
        do_serve("serve1");

        ev(1, 5, 0, "hit5");
        ev(1, 5, 0, "hit5_again");
        ev(1, 63, 0, "hit63");
        ev(1, 60, 0, "hit60");

        ev(0, 0, 1, "lost1");
        ball_lost = 1;
        step("hold_lost_ignored");
        do_hold("hold1");
        do_serve("serve2");
        ev(0, 0, 1, "lost2");
        do_hold("hold2");
        do_serve("serve3");
        ev(0, 0, 1, "lost3");
        brick_hit = 1; brick_idx = 6'd1;
        step("gameover_hit_ignored");

        start = 1; set_reset_exp(); e_st = SERVE; e_serve = 1'b1;
        step("restart1");
        do_serve("serve4");
        for (int k = 0; k < 60; k++) ev(1, k, 0, $sformatf("clear%0d", k));
        ball_lost = 1;
        step("win_lost_ignored");

        start = 1; set_reset_exp(); e_st = SERVE; e_serve = 1'b1;
        step("restart2");
        do_serve("serve5");
        for (int k = 0; k < 58; k++) ev(1, k, 0, $sformatf("clr%0d", k));
        ev(1, 58, 1, "hit_lost_not_last");
        do_hold("hold3");
        do_serve("serve6");
        ev(1, 59, 1, "hit_lost_last");

        start = 1; set_reset_exp(); e_st = SERVE; e_serve = 1'b1;
        step("restart3");
        frame_tick = 1;
        step("serve_tick_before_rst");
        rst = 1; start = 1; set_reset_exp();
        step("rst_over_start");
        rst = 1;
        step("rst_hold");
        rst = 0;
        step("idle_after_rst");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
